// File: rtl/dual_issue_pkg.sv
// dual_issue_pkg: shared types and constants for the dual-issue hazard controller
package dual_issue_pkg;
  localparam int REG_W = 5;
  typedef enum logic {PAIR, SECOND} issue_state_t;
  // Kept for debug visibility of why a pair was split
  typedef enum logic [1:0] {RAW, MEM, WAW, CTL} split_reason_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags any enabled source matching a nonzero EX load destination
module load_use_detect #(
  parameter int REG_W = dual_issue_pkg::REG_W
) (
  input  logic [REG_W-1:0]      rd_e0,
  input  logic [REG_W-1:0]      rd_e1,
  input  logic                  load_e0,
  input  logic                  load_e1,
  input  logic [3:0][REG_W-1:0] src,
  input  logic [3:0]            src_en,
  output logic                  hit
);
  logic live0, live1;
  assign live0 = load_e0 && rd_e0 != '0;
  assign live1 = load_e1 && rd_e1 != '0;
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 4; i++)
      hit = hit | (src_en[i] && ((live0 && src[i] == rd_e0) || (live1 && src[i] == rd_e1)));
  end
endmodule

// File: rtl/dual_issue_hazard_ctrl.sv
// dual_issue_hazard_ctrl: splits conflicting pairs, inserts load-use bubbles, flushes on redirect.
// DUAL_ISSUE_STATS_EN adds saturating cnt_pairs/cnt_splits/cnt_lu counters.
module dual_issue_hazard_ctrl #(
  parameter int REG_W = dual_issue_pkg::REG_W
`ifdef DUAL_ISSUE_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] rs1_0,
  input  logic [REG_W-1:0] rs2_0,
  input  logic [REG_W-1:0] rd_0,
  input  logic [REG_W-1:0] rs1_1,
  input  logic [REG_W-1:0] rs2_1,
  input  logic [REG_W-1:0] rd_1,
  input  logic             regwrite_0,
  input  logic             regwrite_1,
  input  logic             mem_0,
  input  logic             mem_1,
  input  logic             ctl_0,
  input  logic [REG_W-1:0] RdE_0,
  input  logic [REG_W-1:0] RdE,
  input  logic             loadE_0,
  input  logic             loadE,
  input  logic             redirect_e,
  input  logic             dmem_stall,
`ifdef DUAL_ISSUE_STATS_EN
  output logic [CNT_W-1:0] cnt_pairs,
  output logic [CNT_W-1:0] cnt_splits,
  output logic [CNT_W-1:0] cnt_lu,
`endif
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             StallE_0,
  output logic             FlushE_0,
  output logic             FlushE_1,
  output logic             split_pending
);
  import dual_issue_pkg::*;
  issue_state_t state, state_n;
  logic split_c, pair, lu_hit, lu;
  logic r2, r3, r4, r5, r6, r7, r8, past_rd, past_lu;
  assign pair    = state == PAIR;
  assign split_c = (regwrite_0 && rd_0 != '0 && (rs1_1 == rd_0 || rs2_1 == rd_0))
                || (mem_0 && mem_1)
                || (regwrite_0 && regwrite_1 && rd_0 == rd_1 && rd_0 != '0)
                || ctl_0;
  // Slot-1 sources only matter when slot 1 actually issues this cycle
  load_use_detect #(.REG_W(REG_W)) u_lu (
    .rd_e0(RdE_0), .rd_e1(RdE), .load_e0(loadE_0), .load_e1(loadE),
    .src({rs2_1, rs1_1, rs2_0, rs1_0}),
    .src_en(pair ? {~split_c, ~split_c, 2'b11} : 4'b1100),
    .hit(lu_hit)
  );
  assign lu      = id_valid && lu_hit;
  assign r2      = !rst && dmem_stall;
  assign r3      = !rst && !dmem_stall && redirect_e;
  assign past_rd = !rst && !dmem_stall && !redirect_e;
  assign r4      = past_rd && lu;
  assign past_lu = past_rd && !lu && id_valid;
  assign r5      = past_rd && !lu && !id_valid;
  assign r6      = past_lu && pair && split_c;
  assign r7      = past_lu && pair && !split_c;
  assign r8      = past_lu && !pair;
  assign StallF        = r2 || r4 || r6;
  assign StallD        = StallF;
  assign FlushD        = r3;
  assign StallE_0      = r2;
  assign FlushE_0      = rst || r3 || r4 || r5 || r8;
  assign FlushE_1      = rst || r3 || r4 || r5 || r6;
  assign split_pending = state == SECOND;
  assign state_n = (r3 || r5 || r8) ? PAIR : r6 ? SECOND : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= PAIR;
    else     state <= state_n;
`ifdef DUAL_ISSUE_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_pairs  <= '0;
      cnt_splits <= '0;
      cnt_lu     <= '0;
    end else begin
      if (r7 && !(&cnt_pairs))  cnt_pairs  <= cnt_pairs + CNT_W'(1);
      if (r6 && !(&cnt_splits)) cnt_splits <= cnt_splits + CNT_W'(1);
      if (r4 && !(&cnt_lu))     cnt_lu     <= cnt_lu + CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_dual_issue_hazard_ctrl.sv
// tb_dual_issue_hazard_ctrl: directed literal checks plus randomized run against a rule-table model
module tb_dual_issue_hazard_ctrl;
  logic clk = 0, rst = 1;
  logic id_valid, regwrite_0, regwrite_1, mem_0, mem_1, ctl_0, loadE_0, loadE, redirect_e, dmem_stall;
  logic [4:0] rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1, RdE_0, RdE;
  logic StallF, StallD, FlushD, StallE_0, FlushE_0, FlushE_1, split_pending;
  int checks = 0, errors = 0;
  bit m_pend = 0, m_next = 0;
  logic [6:0] outv;
`ifdef DUAL_ISSUE_STATS_EN
  logic [31:0] cnt_pairs, cnt_splits, cnt_lu;
  int m_pairs = 0, m_splits = 0, m_lu = 0, m_rule = 0;
`endif

  always #5 clk = ~clk;

  dual_issue_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .rs1_0(rs1_0), .rs2_0(rs2_0), .rd_0(rd_0), .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1),
    .regwrite_0(regwrite_0), .regwrite_1(regwrite_1), .mem_0(mem_0), .mem_1(mem_1), .ctl_0(ctl_0),
    .RdE_0(RdE_0), .RdE(RdE), .loadE_0(loadE_0), .loadE(loadE),
    .redirect_e(redirect_e), .dmem_stall(dmem_stall),
`ifdef DUAL_ISSUE_STATS_EN
    .cnt_pairs(cnt_pairs), .cnt_splits(cnt_splits), .cnt_lu(cnt_lu),
`endif
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .StallE_0(StallE_0),
    .FlushE_0(FlushE_0), .FlushE_1(FlushE_1), .split_pending(split_pending)
  );

  assign outv = {StallF, StallD, FlushD, StallE_0, FlushE_0, FlushE_1, split_pending};

  function automatic bit ld_hit(logic [4:0] r);
    return r != 0 && ((loadE_0 && RdE_0 == r) || (loadE && RdE == r));
  endfunction

  // Which numbered priority rule governs this cycle
  function automatic int rule_now();
    bit sp, lu;
    if (rst) return 1;
    if (dmem_stall) return 2;
    if (redirect_e) return 3;
    sp = (regwrite_0 && rd_0 != 0 && (rs1_1 == rd_0 || rs2_1 == rd_0)) || (mem_0 && mem_1)
      || (regwrite_0 && regwrite_1 && rd_0 == rd_1 && rd_0 != 0) || ctl_0;
    if (m_pend) lu = ld_hit(rs1_1) || ld_hit(rs2_1);
    else        lu = ld_hit(rs1_0) || ld_hit(rs2_0) || (!sp && (ld_hit(rs1_1) || ld_hit(rs2_1)));
    if (id_valid && lu) return 4;
    if (!id_valid) return 5;
    if (m_pend) return 8;
    return sp ? 6 : 7;
  endfunction

  // {StallF, StallD, FlushD, StallE_0, FlushE_0, FlushE_1} per rule
  function automatic logic [5:0] rule_out(int r);
    case (r)
      1: return 6'b000011;
      2: return 6'b110100;
      3: return 6'b001011;
      4: return 6'b110011;
      5: return 6'b000011;
      6: return 6'b110001;
      7: return 6'b000000;
      default: return 6'b000010;
    endcase
  endfunction

  always @(negedge clk) begin
    int r;
    logic [6:0] exp;
    r = rule_now();
    exp = {rule_out(r), (r == 1) ? 1'b0 : m_pend};
    checks++;
    if (outv !== exp) begin
      errors++;
      $display("FAIL model rule%0d t=%0t: got %b expected %b", r, $time, outv, exp);
    end
    m_next = (r == 2 || r == 4) ? m_pend : (r == 6);
`ifdef DUAL_ISSUE_STATS_EN
    m_rule = r;
    checks++;
    if (cnt_pairs !== 32'(m_pairs) || cnt_splits !== 32'(m_splits) || cnt_lu !== 32'(m_lu)) begin
      errors++;
      $display("FAIL counters: got %0d/%0d/%0d expected %0d/%0d/%0d",
               cnt_pairs, cnt_splits, cnt_lu, m_pairs, m_splits, m_lu);
    end
`endif
  end

  always @(posedge clk or posedge rst) begin
    if (rst) m_pend <= 0;
    else     m_pend <= m_next;
`ifdef DUAL_ISSUE_STATS_EN
    if (rst) begin m_pairs <= 0; m_splits <= 0; m_lu <= 0; end
    else begin
      if (m_rule == 7) m_pairs  <= m_pairs + 1;
      if (m_rule == 6) m_splits <= m_splits + 1;
      if (m_rule == 4) m_lu     <= m_lu + 1;
    end
`endif
  end

  task automatic clr();
    {id_valid, regwrite_0, regwrite_1, mem_0, mem_1, ctl_0, loadE_0, loadE, redirect_e, dmem_stall} = '0;
    {rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1, RdE_0, RdE} = '0;
    id_valid = 1;
  endtask

  task automatic indep();
    clr();
    rd_0 = 3; rd_1 = 4; rs1_0 = 1; rs2_0 = 2; rs1_1 = 5; rs2_1 = 6;
    regwrite_0 = 1; regwrite_1 = 1;
  endtask

  task automatic chk(input logic [6:0] exp, input string nm);
    @(negedge clk);
    checks++;
    if (outv !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, outv, exp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit prev_dm, prev_rd;
    clr();
    @(posedge clk); #1;
    chk(7'b0000110, "reset");
    rst = 0;
    indep();
    chk(7'b0000000, "indep");
    rd_0 = 0; rs1_1 = 0;
    chk(7'b0000000, "indep_x0");
    indep(); rd_0 = 5; rs1_1 = 5; rd_1 = 6;
    chk(7'b1100010, "raw_c0");
    chk(7'b0000101, "raw_c1");
    indep();
    chk(7'b0000000, "raw_c2");
    clr(); RdE_0 = 7; loadE_0 = 1; rs2_0 = 7;
    chk(7'b1100110, "lu_bubble");
    loadE_0 = 0;
    chk(7'b0000000, "lu_after");
    indep(); ctl_0 = 1;
    chk(7'b1100010, "ctl_split");
    redirect_e = 1;
    chk(7'b0010111, "redirect_second");
    indep();
    chk(7'b0000000, "post_redirect");
    indep(); mem_0 = 1; mem_1 = 1;
    chk(7'b1100010, "mem_split");
    dmem_stall = 1;
    for (int i = 0; i < 3; i++) chk(7'b1101001, "dmem_hold");
    dmem_stall = 0;
    chk(7'b0000101, "dmem_release");
    indep();
    chk(7'b0000000, "dmem_after");
    indep(); rd_0 = 9; rd_1 = 9;
    chk(7'b1100010, "waw_split");
    chk(7'b0000101, "waw_second");
    id_valid = 0;
    chk(7'b0000110, "no_valid");
    indep(); ctl_0 = 1;
    chk(7'b1100010, "split_pre_rst");
    rst = 1; #1;
    checks++;
    if (outv !== 7'b0000110) begin
      errors++;
      $display("FAIL rst_mid_split: got %b expected %b", outv, 7'b0000110);
    end
    @(posedge clk); #1;
    rst = 0;
    prev_dm = 0; prev_rd = 0;
    for (int n = 0; n < 3000; n++) begin
      rs1_0 = 5'($urandom_range(0, 7)); rs2_0 = 5'($urandom_range(0, 7)); rd_0 = 5'($urandom_range(0, 7));
      rs1_1 = 5'($urandom_range(0, 7)); rs2_1 = 5'($urandom_range(0, 7)); rd_1 = 5'($urandom_range(0, 7));
      RdE_0 = 5'($urandom_range(0, 7)); RdE = 5'($urandom_range(0, 7));
      regwrite_0 = 1'($urandom); regwrite_1 = 1'($urandom);
      mem_0 = 1'($urandom); mem_1 = 1'($urandom);
      ctl_0 = $urandom_range(0, 5) == 0;
      loadE_0 = $urandom_range(0, 3) == 0; loadE = $urandom_range(0, 3) == 0;
      id_valid = $urandom_range(0, 9) != 0;
      dmem_stall = $urandom_range(0, 7) == 0;
      redirect_e = prev_dm ? prev_rd : ($urandom_range(0, 11) == 0);
      rst = $urandom_range(0, 199) == 0;
      prev_dm = dmem_stall; prev_rd = redirect_e;
      @(posedge clk); #1;
    end
    rst = 0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_issue_hazard_ctrl.md
# dual_issue_hazard_ctrl

Issue and hazard controller for the dual-issue RISC-V core. It sits at the decode/execute boundary and drives the stall and flush controls of the ID/EX pipeline register: `StallE_0`, `FlushE_0` and `FlushE_1`, plus the fetch/decode stalls. It splits dependent or conflicting instruction pairs over two cycles, inserts load-use bubbles, and flushes on taken-branch redirects.

## Interface
Parameters:
- `REG_W`, 5: register-address width.
- `CNT_W`, 32: statistics-counter width (used only with the macro below).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  decode stage holds a valid instruction pair.
- `rs1_0`, `rs2_0`, `rd_0`  in  REG_W  slot-0 sources and destination.
- `rs1_1`, `rs2_1`, `rd_1`  in  REG_W  slot-1 sources and destination.
- `regwrite_0`, `regwrite_1`  in  1  slot writes a register.
- `mem_0`, `mem_1`  in  1  slot performs a load or store.
- `ctl_0`  in  1  slot 0 is a branch or jump.
- `RdE_0`, `RdE`  in  REG_W  destination registers in EX, pipe 0 and pipe 1.
- `loadE_0`, `loadE`  in  1  EX instruction is a load (`MemReadE != 0`).
- `redirect_e`  in  1  taken branch or jump resolved in EX.
- `dmem_stall`  in  1  data memory busy.
- `StallF`, `StallD`  out  1  freeze the PC and the IF/ID register.
- `FlushD`  out  1  clear the IF/ID register.
- `StallE_0`  out  1  hold ID/EX pipe 0.
- `FlushE_0`, `FlushE_1`  out  1  insert a bubble into ID/EX pipe 0 or pipe 1.
- `split_pending`  out  1  FSM is in state SECOND.

## Operation
- FSM states:
  - PAIR: the full pair is eligible to issue.
  - SECOND: slot 0 has issued; slot 1 is still pending.
- Split condition, evaluated only in PAIR with `id_valid`. The pair is split if any of the following holds:
  - RAW: `regwrite_0` and `rd_0 != 0` and (`rs1_1 == rd_0` or `rs2_1 == rd_0`).
  - Structural: `mem_0 && mem_1`.
  - WAW: both slots write, and `rd_0 == rd_1 != 0`.
  - Control: `ctl_0`.
- Load-use hazard:
  - An EX pipe has its load flag set and a destination `!= 0`, and that destination matches a source of an instruction issuing this cycle.
  - In PAIR, the checked sources are the slot-0 sources, plus the slot-1 sources only when the pair is not split.
  - In SECOND, only the slot-1 sources are checked.
- Outputs are combinational from state and inputs. The first matching rule applies; every output not listed is 0.
  1. `rst`: `FlushE_0` = `FlushE_1` = 1.
  2. `dmem_stall`: `StallF` = `StallD` = `StallE_0` = 1. State holds. `FlushE_1` = 0, so pipe 1 recaptures an unchanged decode stage.
  3. `redirect_e`: `FlushD` = `FlushE_0` = `FlushE_1` = 1. Next state is PAIR.
  4. Load-use hazard: `StallF` = `StallD` = 1, `FlushE_0` = `FlushE_1` = 1. State holds.
  5. `!id_valid`: `FlushE_0` = `FlushE_1` = 1. Next state is PAIR.
  6. PAIR with the split condition: `StallF` = `StallD` = 1, `FlushE_1` = 1 (slot 0 issues alone). Next state is SECOND.
  7. PAIR without the split condition: both slots issue; all outputs 0.
  8. SECOND: `FlushE_0` = 1; slot 1 issues in pipe 1. Next state is PAIR.
- `redirect_e` must be held by EX for as long as `dmem_stall` is asserted.

## Timing
- Reset value: state is PAIR and the counters are 0. While `rst` is asserted, all outputs follow rule 1.
- Decision latency is 0 cycles; the outputs are valid in the same cycle as the decode inputs.
- A split pair occupies exactly 2 issue cycles. Each load-use hazard adds 1 bubble cycle.
- When redirect and split occur together, redirect wins and the SECOND state is abandoned.
- If reset is asserted mid-split, the state returns to PAIR immediately.

## Configuration
- Macro `DUAL_ISSUE_STATS_EN`.
- When defined: adds three output counters of width CNT_W, each saturating at all ones:
  - `cnt_pairs`: pairs issued dual, incremented on rule 7.
  - `cnt_splits`: incremented on rule 6.
  - `cnt_lu`: incremented on rule 4.
  - Counters do not count while `dmem_stall` is asserted.
- When undefined: the counter ports and logic are absent, with identical control behaviour.

## Structure
- Shared package `dual_issue_pkg`:
  - State enum `issue_state_t` (PAIR, SECOND).
  - The `REG_W` constant.
  - Split-reason enum (RAW, MEM, WAW, CTL), for debug.
- One sub-module, `load_use_detect`: a combinational comparator of the EX load destinations against up to four sources.

## Test plan
- RAW split: pair `add x5,...` then `sub x6,x5,x1` → cycle 0: `FlushE_1` = 1, `StallD` = 1. Cycle 1: `FlushE_0` = 1, `StallD` = 0. Cycle 2: state is PAIR.
- Load-use: `RdE_0` = 7, `loadE_0` = 1, `rs2_0` = 7 → `StallF` = `StallD` = `FlushE_0` = `FlushE_1` = 1 for one cycle, then a normal issue.
- Independent pair, `rd_0` = 3 and `rd_1` = 4 → all outputs 0. Rerun with `rd_0` = 0 and `rs1_1` = 0: still no split.
- `redirect_e` during SECOND → `FlushD` = `FlushE_0` = `FlushE_1` = 1, then state is PAIR.
- `dmem_stall` held 3 cycles during SECOND → `StallE_0` = 1 for 3 cycles, state stays SECOND, then the slot-1 issue completes.
- With `DUAL_ISSUE_STATS_EN`: 2 dual pairs, 1 split, 1 load-use → counters read 2, 1, 1. Asserting `rst` mid-run clears them.
